// File: rtl/wait_state_ram_pkg.sv
// Shared definitions for the wait-state system RAM.
//   - opcode constants of the basic processor (used to build the boot image)
//   - ram_state_t : controller states
//   - preload_image(addr, word_w, op_w) : boot program word for an address
package ram_pkg;

  localparam logic [2:0] LOAD  = 3'b000;
  localparam logic [2:0] STORE = 3'b001;
  localparam logic [2:0] ADD   = 3'b010;
  localparam logic [2:0] SUB   = 3'b011;
  localparam logic [2:0] BNE   = 3'b100;

  typedef enum logic [1:0] {INIT, IDLE, BUSY} ram_state_t;

  // Opcode sits in the top op_w bits, the operand is zero-padded below it.
  // Returned 32 bits wide; callers truncate to their word width.
  function automatic logic [31:0] preload_image(input int unsigned addr,
                                                input int unsigned word_w = 8,
                                                input int unsigned op_w   = 3);
    logic [31:0] w;
    int unsigned sh;
    sh = word_w - op_w;
    case (addr)
      0:       w = (32'(LOAD)  << sh) | 32'd4;
      1:       w = (32'(ADD)   << sh) | 32'd5;
      2:       w = (32'(STORE) << sh) | 32'd6;
      3:       w = (32'(BNE)   << sh) | 32'd7;
      4, 5:    w = 32'd2;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wait_state_ram_if.sv
// Command/handshake bundle between the sequencer (master) and the RAM (slave).
//   MDR_bus  : drive mdr onto sysbus
//   load_MDR : mdr <= sysbus
//   load_MAR : mar <= sysbus low bits
//   CS       : start a memory access
//   R_NW     : 1 = read, 0 = write
//   ready    : RAM idle and accepting commands
//   err      : sticky protocol-violation flag
interface wait_state_ram_if;
  logic MDR_bus;
  logic load_MDR;
  logic load_MAR;
  logic CS;
  logic R_NW;
  logic ready;
  logic err;

  modport master (output MDR_bus, load_MDR, load_MAR, CS, R_NW,
                  input  ready, err);
  modport slave  (input  MDR_bus, load_MDR, load_MAR, CS, R_NW,
                  output ready, err);
endinterface

// File: rtl/wait_state_ram_array.sv
// ram_array: DEPTH x WORD_W storage, one synchronous write port and an
// asynchronous (combinational) read port. No reset; contents are rewritten
// by the controller's INIT sweep.
//   clock        : write clock
//   we/waddr/wdata : write port
//   raddr/rdata  : combinational read port
module ram_array #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  localparam int DEPTH = 2**ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/wait_state_ram.sv
// wait_state_ram: system RAM with MAR/MDR, configurable wait states, a
// post-reset preload sweep and a sticky protocol-error flag.
//   clock, n_reset : rising-edge clock, async active-low reset
//   bus            : command/handshake bundle (slave side)
//   sysbus         : shared tri-state system bus, driven with mdr on MDR_bus
module wait_state_ram
  import ram_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int OP_W    = 3,
  parameter int ADDR_W  = WORD_W - OP_W,
  parameter int WAIT    = 2,
  parameter int PRELOAD = 1
) (
  input  logic              clock,
  input  logic              n_reset,
  wait_state_ram_if.slave   bus,
  inout  wire  [WORD_W-1:0] sysbus
);
  localparam int DEPTH = 2**ADDR_W;

  ram_state_t        state, state_nx;
  logic [ADDR_W-1:0] mar, init_cnt;
  logic [WORD_W-1:0] mdr;
  logic [3:0]        wait_cnt;
  logic              rnw_q, ready_q, err_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata, mem_rdata;
  logic              ld_mar, ld_mdr, rd_mdr, start, set_err;

  ram_array #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_array (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mar),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) state <= INIT;
    else          state <= state_nx;

  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_waddr = mar;
    mem_wdata = mdr;
    ld_mar    = 1'b0;
    ld_mdr    = 1'b0;
    rd_mdr    = 1'b0;
    start     = 1'b0;
    set_err   = 1'b0;
    case (state)
      // One word per edge; commands are silently ignored while preloading.
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_cnt;
        mem_wdata = (PRELOAD != 0) ?
                    WORD_W'(preload_image(32'(init_cnt), WORD_W, OP_W)) : '0;
        if (init_cnt == ADDR_W'(DEPTH - 1)) state_nx = IDLE;
      end
      // Priority load_MAR > load_MDR > CS; only one action per edge.
      IDLE: begin
        if (bus.load_MAR)      ld_mar = 1'b1;
        else if (bus.load_MDR) ld_mdr = 1'b1;
        else if (bus.CS) begin
          if (WAIT == 0) begin
            if (bus.R_NW) rd_mdr = 1'b1;
            else          mem_we = 1'b1;
          end else begin
            start    = 1'b1;
            state_nx = BUSY;
          end
        end
      end
      // Access lands on the edge where the counter reads 1, so a command
      // sampled at E0 completes at E0+WAIT.
      BUSY: begin
        set_err = bus.load_MAR | bus.load_MDR | bus.CS;
        if (wait_cnt == 4'd1) begin
          state_nx = IDLE;
          if (rnw_q) rd_mdr = 1'b1;
          else       mem_we = 1'b1;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      mar      <= '0;
      mdr      <= '0;
      init_cnt <= '0;
      wait_cnt <= '0;
      rnw_q    <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= (state_nx == IDLE);
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      if (ld_mar) mar <= sysbus[ADDR_W-1:0];
      if (ld_mdr)      mdr <= sysbus;
      else if (rd_mdr) mdr <= mem_rdata;
      if (start) begin
        wait_cnt <= 4'(WAIT);
        rnw_q    <= bus.R_NW;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (set_err) err_q <= 1'b1;
    end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign sysbus    = bus.MDR_bus ? mdr : {WORD_W{1'bz}};
endmodule

// File: tb/tb_wait_state_ram.sv
// Bench for wait_state_ram: one instance with WAIT=2 and one with WAIT=0 fed
// the same command stream. Expected bus values are queued when a read is
// issued and checked by an independent monitor on the falling edge.
module tb_wait_state_ram;
  localparam int DEPTH  = 32;
  localparam int WAIT_A = 2;

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  always #5 clock = ~clock;

  logic lm = 0, ld = 0, cs = 0, rnw = 0, mb = 0, drv_en = 0;
  logic [7:0] drv = 8'h00;
  wire  [7:0] sysbus_a, sysbus_0;
  assign sysbus_a = drv_en ? drv : 8'bz;
  assign sysbus_0 = drv_en ? drv : 8'bz;

  wait_state_ram_if bus_a();
  wait_state_ram_if bus_0();
  assign bus_a.MDR_bus = mb;  assign bus_0.MDR_bus = mb;
  assign bus_a.load_MAR = lm; assign bus_0.load_MAR = lm;
  assign bus_a.load_MDR = ld; assign bus_0.load_MDR = ld;
  assign bus_a.CS = cs;       assign bus_0.CS = cs;
  assign bus_a.R_NW = rnw;    assign bus_0.R_NW = rnw;

  wait_state_ram #(.WORD_W(8), .OP_W(3), .ADDR_W(5), .WAIT(WAIT_A), .PRELOAD(1)) u_dut_a (
    .clock(clock), .n_reset(n_reset), .bus(bus_a), .sysbus(sysbus_a));
  wait_state_ram #(.WORD_W(8), .OP_W(3), .ADDR_W(5), .WAIT(0), .PRELOAD(1)) u_dut_0 (
    .clock(clock), .n_reset(n_reset), .bus(bus_0), .sysbus(sysbus_0));

  int n_cmp = 0, n_bad = 0;
  logic [7:0] mem_m [DEPTH];
  logic [4:0] mar_m;
  logic [7:0] mdr_m;
  logic [7:0] exp_q [$];
  logic [7:0] e_val;
  bit chk0 = 0;
  int drops0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Boot program: LOAD 4, ADD 5, STORE 6, BNE 7, then data words 2, 2.
  function automatic logic [7:0] img(input int a);
    case (a)
      0: return 8'h04;
      1: return 8'h45;
      2: return 8'h26;
      3: return 8'h87;
      4, 5: return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = img(i);
    mar_m = '0;
    mdr_m = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops on every bus read; also counts any ready drop of the
  // zero-wait instance while it is expected to stay idle.
  always @(negedge clock) begin
    if (chk0 && bus_0.ready !== 1'b1) drops0++;
    if (mb) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else begin
        e_val = exp_q.pop_front();
        check("bus_a", 32'(sysbus_a), 32'(e_val));
        check("bus_0", 32'(sysbus_0), 32'(e_val));
      end
    end
  end

  task automatic read_bus();
    mb = 1'b1;
    exp_q.push_back(mdr_m);
    tick();
    mb = 1'b0;
  endtask

  // Called right after reset release: reads the bus once (mdr is 0), then
  // throws ignored commands at the RAM, and counts edges until ready.
  task automatic wait_init();
    int n;
    n = 0;
    do begin
      mb = (n == 0);
      if (n == 0) exp_q.push_back(8'h00);
      {lm, ld, cs, drv_en} = (n >= 1 && n <= 3) ? 4'hF : 4'h0;
      rnw = 1'b0;
      drv = 8'hFF;
      tick();
      n++;
    end while (bus_a.ready !== 1'b1 && n < 200);
    {mb, lm, ld, cs, drv_en} = '0;
    check("init_edges", 32'(n), 32'(DEPTH));
    check("init_ready0", 32'(bus_0.ready), 32'd1);
    check("init_err", 32'(bus_a.err), 32'd0);
  endtask

  task automatic cmd(input bit l_mar, input bit l_mdr, input bit c, input bit r,
                     input logic [7:0] v);
    int n;
    bit acc;
    acc = !l_mar && !l_mdr && c;
    lm = l_mar; ld = l_mdr; cs = c; rnw = r; drv = v; drv_en = l_mar | l_mdr;
    tick();
    lm = 0; ld = 0; cs = 0; drv_en = 0;
    if (l_mar)      mar_m = v[4:0];
    else if (l_mdr) mdr_m = v;
    else if (c) begin
      if (r) mdr_m = mem_m[mar_m];
      else   mem_m[mar_m] = mdr_m;
    end
    n = 0;
    while (bus_a.ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("ready_low", 32'(n), acc ? 32'(WAIT_A) : 32'd0);
  endtask

  initial begin
    int n, k;
    reset_model();
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(bus_a.ready), 32'd0);
    check("rst_err", 32'(bus_a.err), 32'd0);
    n_reset = 1'b1;
    wait_init();
    chk0 = 1;

    // Preload readback at 0 (mar untouched by INIT commands), 4 and 5.
    cmd(0, 0, 1, 1, 8'h00); read_bus();
    cmd(1, 0, 0, 0, 8'd4);  cmd(0, 0, 1, 1, 8'h00); read_bus();
    cmd(1, 0, 0, 0, 8'd5);  cmd(0, 0, 1, 1, 8'h00); read_bus();

    // Write / readback.
    cmd(1, 0, 0, 0, 8'd9); cmd(0, 1, 0, 0, 8'hA5); cmd(0, 0, 1, 0, 8'h00);
    cmd(0, 1, 0, 0, 8'h00); read_bus();
    cmd(0, 0, 1, 1, 8'h00); read_bus();

    // Priority: load_MAR beats CS, load_MAR beats load_MDR, load_MDR beats CS.
    cmd(1, 0, 1, 1, 8'd3); read_bus();
    cmd(0, 0, 1, 1, 8'h00); read_bus();
    cmd(1, 1, 0, 0, 8'hE7); read_bus();
    cmd(0, 1, 1, 0, 8'h3C); read_bus();

    // Random traffic; upper bus bits on load_MAR must be ignored.
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1: cmd(1, 0, 0, 0, 8'($urandom));
        2, 3: cmd(0, 1, 0, 0, 8'($urandom));
        4, 5: cmd(0, 0, 1, 1'($urandom_range(0, 1)), 8'h00);
        6:    read_bus();
        7:    cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        default: begin cmd(0, 0, 1, 1, 8'h00); read_bus(); end
      endcase
    end
    check("err_clean", 32'(bus_a.err), 32'd0);

    // Protocol violation: CS held into the busy window.
    cmd(1, 0, 0, 0, 8'd4);
    cs = 1; rnw = 1;
    tick();
    tick();
    cs = 0;
    mdr_m = mem_m[mar_m];
    n = 0;
    while (bus_a.ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("viol_ready", 32'(n), 32'(WAIT_A - 1));
    check("viol_err", 32'(bus_a.err), 32'd1);
    read_bus();
    cmd(0, 1, 0, 0, 8'h5A); cmd(1, 0, 0, 0, 8'd12); cmd(0, 0, 1, 0, 8'h00);
    cmd(0, 0, 1, 1, 8'h00); read_bus();
    check("err_sticky", 32'(bus_a.err), 32'd1);
    check("err0", 32'(bus_0.err), 32'd0);
    check("ready0_drops", 32'(drops0), 32'd0);

    // Reset mid-write of FF to address 4.
    cmd(1, 0, 0, 0, 8'd4); cmd(0, 1, 0, 0, 8'hFF);
    cs = 1; rnw = 0;
    tick();
    cs = 0;
    check("busy_pre_rst", 32'(bus_a.ready), 32'd0);
    chk0 = 0;
    n_reset = 1'b0;
    #1;
    check("rst_err_clr", 32'(bus_a.err), 32'd0);
    check("rst_ready_clr", 32'(bus_a.ready), 32'd0);
    #1;
    n_reset = 1'b1;
    reset_model();
    wait_init();
    chk0 = 1;
    cmd(1, 0, 0, 0, 8'd4); cmd(0, 0, 1, 1, 8'h00); read_bus();
    cmd(1, 0, 0, 0, 8'd3); cmd(0, 0, 1, 1, 8'h00); read_bus();
    repeat (2) tick();
    check("ready0_drops_end", 32'(drops0), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
